// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter: default bus geometry, FSM
// encoding and the wait-counter width used by control and datapath alike.
package cpu_pkg;

    localparam int AW_DEF     = 16;
    localparam int DW_DEF     = 32;
    localparam int RD_LAT_DEF = 2;
    localparam int CNT_W      = 4;   // holds RD_LAT-1 for RD_LAT up to 15

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } src_e;

    function automatic logic [CNT_W-1:0] wait_init(input int rd_lat);
        return CNT_W'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and single-port memory signals between the
// CPU side, the arbiter and the memory.
interface mem_arbiter_if #(
    parameter int AW = cpu_pkg::AW_DEF,
    parameter int DW = cpu_pkg::DW_DEF
);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a sole requester wins; on a tie the side that
// was not granted last wins. req[0]/gnt[0] is fetch, req[1]/gnt[1] is data.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_dm,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] |  last_dm);
    assign gnt[1] = req[1] & (~req[0] | ~last_dm);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory
// through an IDLE -> ISSUE -> (WAIT) -> RESP sequence with registered outputs.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_INIT = wait_init(RD_LAT);

    arb_state_e       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             last_dm_q,  last_dm_d;
    src_e             win_q,      win_d;
    logic [AW-1:0]    addr_q,     addr_d;
    logic             we_q,       we_d;
    logic [DW-1:0]    wdata_q,    wdata_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d;
    logic [DW-1:0]    dm_rdata_q, dm_rdata_d;
    logic             if_ack_q,   if_ack_d;
    logic             dm_ack_q,   dm_ack_d;
    logic             mem_en_q,   mem_en_d;
    logic             mem_we_q,   mem_we_d;
    logic             busy_q,     busy_d;
    logic [1:0]       gnt;

    rr_pick2 u_pick (
        .req     ({bus.dm_req, bus.if_req}),
        .last_dm (last_dm_q),
        .gnt     (gnt)
    );

    always_comb begin
        // NOTE: every _d starts from its held value so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_dm_d  = last_dm_q;
        win_d      = win_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    win_d     = gnt[1] ? SRC_DM : SRC_IF;
                    last_dm_d = gnt[1];
                    addr_d    = gnt[1] ? bus.dm_addr : bus.if_addr;
                    we_d      = gnt[1] & bus.dm_we;
                    wdata_d   = gnt[1] ? bus.dm_wdata : '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (win_q == SRC_DM) dm_rdata_d = bus.mem_rdata;
                    else                 if_rdata_d = bus.mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so they line up with it.
        mem_en_d = (state_d == ST_ISSUE);
        mem_we_d = mem_en_d & we_d;
        busy_d   = (state_d != ST_IDLE);
        if_ack_d = (state_d == ST_RESP) & (win_d == SRC_IF);
        dm_ack_d = (state_d == ST_RESP) & (win_d == SRC_DM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_dm_q  <= 1'b1;
            win_q      <= SRC_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dm_q  <= last_dm_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at RD_LAT = 2, 1 and 15 with a latency-exact
// memory model and a queue of expected completions.
module tb_mem_arbiter;
    import cpu_pkg::*;

    localparam int AW = AW_DEF;
    localparam int DW = DW_DEF;

    typedef struct {
        int          sel;
        logic        is_dm;
        logic        is_load;
        logic [31:0] rdata;
        int          ack_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    int            rd_cyc  [3] = '{-1, -1, -1};
    logic [AW-1:0] rd_addr [3];

    mem_arbiter_if #(.AW(AW), .DW(DW)) b2 ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) b15 ();

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2))  u_dut2  (.clk(clk), .rst(rst), .bus(b2));
    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1))  u_dut1  (.clk(clk), .rst(rst), .bus(b1));
    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(15)) u_dut15 (.clk(clk), .rst(rst), .bus(b15));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h8123_0001 + 32'(a);
    endfunction

    // Memory: read data is valid only in the cycle RD_LAT after the strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b2.mem_en && !b2.mem_we)   begin rd_cyc[0] <= cyc + 2;  rd_addr[0] <= b2.mem_addr;  end
        if (b1.mem_en && !b1.mem_we)   begin rd_cyc[1] <= cyc + 1;  rd_addr[1] <= b1.mem_addr;  end
        if (b15.mem_en && !b15.mem_we) begin rd_cyc[2] <= cyc + 15; rd_addr[2] <= b15.mem_addr; end
    end

    always @(negedge clk) begin
        b2.mem_rdata  <= (cyc == rd_cyc[0]) ? mem_word(rd_addr[0]) : (32'hBAD0_BAD0 ^ 32'(cyc));
        b1.mem_rdata  <= (cyc == rd_cyc[1]) ? mem_word(rd_addr[1]) : (32'hBAD1_BAD1 ^ 32'(cyc));
        b15.mem_rdata <= (cyc == rd_cyc[2]) ? mem_word(rd_addr[2]) : (32'hBADF_BADF ^ 32'(cyc));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] acks(input int sel);
        case (sel)
            0:       return {b2.if_ack,  b2.dm_ack};
            1:       return {b1.if_ack,  b1.dm_ack};
            default: return {b15.if_ack, b15.dm_ack};
        endcase
    endfunction

    function automatic logic [31:0] rdata(input int sel, input logic is_dm);
        case (sel)
            0:       return is_dm ? b2.dm_rdata  : b2.if_rdata;
            1:       return is_dm ? b1.dm_rdata  : b1.if_rdata;
            default: return is_dm ? b15.dm_rdata : b15.if_rdata;
        endcase
    endfunction

    task automatic push_exp(input int sel, input logic is_dm, input logic is_load,
                            input logic [31:0] data, input int ack_cyc);
        exp_t e;
        e.sel = sel; e.is_dm = is_dm; e.is_load = is_load; e.rdata = data; e.ack_cyc = ack_cyc;
        sb.push_back(e);
    endtask

    // Pops the oldest expectation and waits (bounded) for the matching ACK.
    task automatic wait_ack(input int budget);
        exp_t       e;
        logic [1:0] a;
        int         n;
        if (sb.size() == 0) begin
            check("sb_nonempty", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        n = 0;
        a = 2'b00;
        while (a == 2'b00 && n < budget) begin
            @(negedge clk);
            n++;
            a = acks(e.sel);
        end
        check("ack_seen", 64'(a != 2'b00), 64'd1);
        if (a != 2'b00) begin
            check("ack_port", 64'(a), e.is_dm ? 64'd1 : 64'd2);
            check("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
            if (e.is_load) check("ack_rdata", 64'(rdata(e.sel, e.is_dm)), 64'(e.rdata));
        end
    endtask

    initial begin
        int n_ack;

        rst = 1'b0;
        b2.if_req = 1'b0;  b2.if_addr = '0;  b2.dm_req = 1'b0;  b2.dm_we = 1'b0;  b2.dm_addr = '0;  b2.dm_wdata = '0;
        b1.if_req = 1'b0;  b1.if_addr = '0;  b1.dm_req = 1'b0;  b1.dm_we = 1'b0;  b1.dm_addr = '0;  b1.dm_wdata = '0;
        b15.if_req = 1'b0; b15.if_addr = '0; b15.dm_req = 1'b0; b15.dm_we = 1'b0; b15.dm_addr = '0; b15.dm_wdata = '0;
        #2 rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({b2.busy, b2.if_ack, b2.dm_ack, b2.mem_en, b2.mem_we}), 64'd0);
        check("rst_bus", 64'({b2.mem_addr, b2.mem_wdata}), 64'd0);
        check("rst_rdata", 64'({b2.if_rdata, b2.dm_rdata}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch at 0x0004
        b2.if_req = 1'b1; b2.if_addr = 16'h0004;
        push_exp(0, 1'b0, 1'b1, 32'h8123_0005, cyc + 4);
        @(negedge clk);
        check("fetch_issue", 64'({b2.mem_en, b2.mem_we, b2.busy}), 64'b101);
        check("fetch_addr", 64'(b2.mem_addr), 64'h0004);
        wait_ack(12);
        b2.if_req = 1'b0;
        @(negedge clk);
        check("fetch_ack_pulse", 64'({acks(0), b2.busy, b2.mem_en}), 64'd0);
        check("fetch_rdata_hold", 64'(b2.if_rdata), 64'h8123_0005);

        // Data load at 0x0020
        b2.dm_req = 1'b1; b2.dm_we = 1'b0; b2.dm_addr = 16'h0020;
        push_exp(0, 1'b1, 1'b1, 32'h8123_0021, cyc + 4);
        wait_ack(12);
        b2.dm_req = 1'b0;
        @(negedge clk);

        // Store 0xDEADBEEF to 0x0010
        b2.dm_req = 1'b1; b2.dm_we = 1'b1; b2.dm_addr = 16'h0010; b2.dm_wdata = 32'hDEAD_BEEF;
        push_exp(0, 1'b1, 1'b0, 32'h0, cyc + 2);
        @(negedge clk);
        check("store_issue", 64'({b2.mem_en, b2.mem_we}), 64'b11);
        check("store_bus", 64'({b2.mem_addr, b2.mem_wdata}), {16'h0, 16'h0010, 32'hDEAD_BEEF});
        wait_ack(8);
        b2.dm_req = 1'b0; b2.dm_we = 1'b0;
        check("store_keeps_dm_rdata", 64'(b2.dm_rdata), 64'h8123_0021);
        check("store_keeps_if_rdata", 64'(b2.if_rdata), 64'h8123_0005);
        @(negedge clk);

        // Reset in the middle of a load's WAIT
        b2.dm_req = 1'b1; b2.dm_addr = 16'h0030;
        repeat (2) @(negedge clk);
        check("abort_in_wait", 64'({b2.busy, b2.mem_en}), 64'b10);
        rst = 1'b1;
        #1;
        check("abort_async", 64'({b2.busy, b2.if_ack, b2.dm_ack, b2.mem_en}), 64'd0);
        check("abort_rdata", 64'({b2.if_rdata, b2.dm_rdata}), 64'd0);
        b2.dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_ack = 0;
        repeat (8) begin
            @(negedge clk);
            if (acks(0) != 2'b00) n_ack++;
        end
        check("abort_no_ack", 64'(n_ack), 64'd0);
        check("abort_idle", 64'(b2.busy), 64'd0);

        // Both requesters held: grant order IF, DM, IF with one IDLE between
        b2.if_req = 1'b1; b2.if_addr = 16'h0040;
        b2.dm_req = 1'b1; b2.dm_we = 1'b0; b2.dm_addr = 16'h0050;
        push_exp(0, 1'b0, 1'b1, 32'h8123_0041, cyc + 4);
        push_exp(0, 1'b1, 1'b1, 32'h8123_0051, cyc + 9);
        push_exp(0, 1'b0, 1'b1, 32'h8123_0041, cyc + 14);
        wait_ack(12);
        wait_ack(12);
        wait_ack(12);
        b2.if_req = 1'b0; b2.dm_req = 1'b0;
        check("rr_dm_rdata_hold", 64'(b2.dm_rdata), 64'h8123_0051);
        @(negedge clk);

        // Inputs change while the access is in flight
        b2.dm_req = 1'b1; b2.dm_we = 1'b0; b2.dm_addr = 16'h0060;
        push_exp(0, 1'b1, 1'b1, 32'h8123_0061, cyc + 4);
        @(negedge clk);
        check("inflight_issue_addr", 64'(b2.mem_addr), 64'h0060);
        b2.dm_addr = 16'hFFFF; b2.dm_we = 1'b1; b2.dm_wdata = 32'h1234_5678;
        #1;
        check("inflight_bus_held", 64'({b2.mem_addr, b2.mem_we, b2.mem_en}), {45'h0, 16'h0060, 1'b0, 1'b1});
        @(negedge clk);
        check("inflight_addr_wait", 64'(b2.mem_addr), 64'h0060);
        wait_ack(12);
        b2.dm_req = 1'b0; b2.dm_we = 1'b0;
        @(negedge clk);

        // Latency extremes: RD_LAT = 1 and RD_LAT = 15
        b1.dm_req = 1'b1; b1.dm_addr = 16'h0070;
        push_exp(1, 1'b1, 1'b1, 32'h8123_0071, cyc + 3);
        wait_ack(10);
        b1.dm_req = 1'b0;
        @(negedge clk);
        b15.dm_req = 1'b1; b15.dm_addr = 16'h0080;
        push_exp(2, 1'b1, 1'b1, 32'h8123_0081, cyc + 17);
        wait_ack(30);
        b15.dm_req = 1'b0;
        repeat (2) @(negedge clk);
        check("lat15_idle", 64'({b15.busy, b1.busy}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 16, address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter RD_LAT, 2, memory read latency in cycles; legal 1..15.
REQ-004 CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 IF_REQ  input  1  instruction-fetch read request.
REQ-007 IF_ADDR  input  AW  fetch address.
REQ-008 IF_RDATA  output  DW  fetched word; holds until next IF_ACK.
REQ-009 IF_ACK  output  1  one-cycle fetch completion pulse.
REQ-010 DM_REQ  input  1  data (lod/str) request.
REQ-011 DM_WE  input  1  1 = store, 0 = load.
REQ-012 DM_ADDR  input  AW  data address.
REQ-013 DM_WDATA  input  DW  store data.
REQ-014 DM_RDATA  output  DW  loaded word; holds until next load DM_ACK.
REQ-015 DM_ACK  output  1  one-cycle data completion pulse.
REQ-016 MEM_EN, MEM_WE  output  1 each  single-port memory strobe and write enable.
REQ-017 MEM_ADDR  output  AW; MEM_WDATA  output  DW; MEM_RDATA  input  DW.
REQ-018 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-019 The block SHALL use FSM states IDLE, ISSUE, WAIT and RESP.
REQ-020 IDLE: with any REQ high, pick a winner and latch its address, DM_WE and DM_WDATA (fetch forces WE=0), then go to ISSUE; otherwise stay.
REQ-021 Arbitration: a sole requester wins; when both are high, the requester not granted last wins (round-robin flag LAST_DM).
REQ-022 ISSUE (exactly 1 cycle): MEM_EN=1, MEM_WE/MEM_ADDR/MEM_WDATA from latched values; store goes to RESP, load goes to WAIT with counter=RD_LAT-1.
REQ-023 MEM_RDATA is valid RD_LAT cycles after the ISSUE cycle; WAIT lasts RD_LAT cycles, captures MEM_RDATA into the winner's RDATA register at the end of the last WAIT cycle, then goes to RESP.
REQ-024 RESP (exactly 1 cycle): winner's ACK=1, then IDLE; MEM_EN=0 in every state except ISSUE.
REQ-025 Latency from REQ seen in IDLE at cycle 0: store ACK at cycle 2; load ACK at cycle 2+RD_LAT.
REQ-026 Requesters SHALL hold REQ until ACK and deassert it at the edge ending the ACK cycle, unless issuing a new request; REQ is only sampled in IDLE.
REQ-027 Input changes after latching SHALL not affect the access in flight.
REQ-028 A losing requester keeps waiting and SHALL be granted at the next IDLE sample if still requesting; starvation is impossible.
REQ-029 A store SHALL not modify DM_RDATA; IF_RDATA and DM_RDATA change only on capture.
REQ-030 Back-to-back: minimum one IDLE cycle between accesses (RESP->IDLE->ISSUE).

Reset
REQ-031 RST high SHALL immediately force IDLE, LAST_DM=1 (fetch wins the first tie), counter=0, and all outputs 0, including RDATA registers.
REQ-032 Reset during ISSUE/WAIT/RESP SHALL abort the access with no ACK; the aborted requester must re-request after reset.

Structure
REQ-033 State encodings and AW/DW/RD_LAT defaults SHALL live in shared package cpu_pkg, reused by ctrl and the datapath.
REQ-034 Sub-module rr_pick2 (2-way round-robin picker: req[1:0], last flag -> one-hot grant) SHALL be instantiated once.

Verification
REQ-035 IF_REQ=1, IF_ADDR=0x0004, MEM_RDATA=0x81230005 at RD_LAT=2 -> MEM_EN in cycle 1; IF_ACK in cycle 4; IF_RDATA=0x81230005.
REQ-036 DM_REQ=1, DM_WE=1, DM_ADDR=0x0010, DM_WDATA=0xDEADBEEF -> cycle 1: MEM_EN=1, MEM_WE=1, same addr/data; DM_ACK in cycle 2; DM_RDATA unchanged.
REQ-037 IF_REQ and DM_REQ both held high after reset for three accesses -> grant order IF, DM, IF.
REQ-038 RST pulsed during WAIT of a load -> BUSY=0 and DM_ACK=0; no ACK afterwards until a new request.
REQ-039 RD_LAT=1 load -> ACK in cycle 3; RD_LAT=15 load -> ACK in cycle 17; DM_ADDR changed in cycle 2 -> MEM_ADDR keeps the latched value.
